fsm_event_logger: RTL and testbench
===================================

Name: fsm_event_logger

Overview:
- Downstream of the experiment FSM. Timestamps every scenario state change and every detonation/trigger edge.
- Records are buffered in a small first-word-fall-through FIFO for the host readout path.
- Gives post-shot timing: FG open delay, phase-shift accuracy and detector busy time, in clock ticks (5 ns at 200 MHz).

Parameters:
- DEPTH, 16, FIFO depth in records; power of two, 4..256.
- TS_W, 32, timestamp counter width.
- DROP_W, 16, dropped-record counter width.

Ports:
- clock  in  1  system clock.
- reset_signal  in  1  synchronous reset, active-low.
- enable  in  1  logging enable; rising edge starts a new shot.
- scenario_state  in  8  FSM state code.
- detonation_signal  in  1  FSM detonation output.
- output_trigger  in  1  FSM trigger output.
- rd_ready  in  1  host consumes the head record.
- clear_flags  in  1  one-cycle pulse; clears overflow and drop_count.
- rd_valid  out  1  head record available.
- rd_data  out  TS_W+16  record: [TS_W+15:16] timestamp, [15:8] state, [7:0] event mask.
- fill_level  out  $clog2(DEPTH)+1  records stored.
- overflow  out  1  sticky: a record was dropped.
- drop_count  out  DROP_W  dropped records, saturating.

Behaviour:
- Reset (reset_signal=0 at a clock edge): all outputs are 0 and the FIFO is emptied.
  - Also cleared: ts counter, prev-sample registers, enable history.
  - Reset mid-operation discards all stored records; no partial record survives.
- Enable edge: enable is sampled into a 2-bit history. A rising edge (01) clears the ts counter to 0 and loads prev-samples with the current inputs; no record is generated that cycle.
- Counter: while enable=1 the ts counter increments by 1 per clock and wraps modulo 2^TS_W. While enable=0 it holds.
- Event mask, computed from current inputs vs prev-samples while enable=1:
  - bit0 state changed.
  - bit1 detonation rise; bit2 detonation fall.
  - bit3 trigger rise; bit4 trigger fall.
  - bit5 timestamp wrap (counter value all-ones this cycle).
  - bits7:6 = 0.
- Write: any nonzero mask writes ONE record at that edge. Simultaneous events merge into one record, never several.
  - Record timestamp is the counter value before the increment.
  - Record state is the current scenario_state.
- Latency: an input change sampled at edge k is written at edge k; rd_valid is high from edge k onward if the FIFO was empty.
- Read: FWFT. rd_data is valid while rd_valid=1; a pop happens on rd_valid and rd_ready. rd_ready while empty is ignored.
- Full: a write while full and not popping is dropped.
  - overflow is set to 1.
  - drop_count increments, saturating at all-ones.
  - Existing records are untouched (oldest kept).
- Full with simultaneous pop and write: both are accepted and fill_level is unchanged.
- Empty with simultaneous write and rd_ready: no pop that cycle; the record appears next cycle.
- clear_flags together with a drop in the same cycle: the drop wins, giving overflow=1 and drop_count=1.
- fill_level counts from 0 to DEPTH exactly.
- prev-samples update every cycle while enable=1, so a level that holds produces no further events.

Optional Feature:
- Macro: EVENT_LOGGER_WRAP_EVENT_EN.
- Defined: bit5 wrap records are generated as described.
- Undefined: no wrap detection; mask bit5 is always 0, and a counter wrap alone writes nothing.

Decomposition:
- Package fsm_logger_pkg holds:
  - event bit index localparams (EV_STATE, EV_DET_RISE, EV_DET_FALL, EV_TRIG_RISE, EV_TRIG_FALL, EV_WRAP);
  - a packed struct event_record_t {ts, state, mask};
  - RECORD_W.
- Sub-module logger_fifo: a synchronous FWFT FIFO parameterised by width and depth, with fill_level, full and empty. The top level holds edge detection, the counter, and the flag and drop logic.

Test Plan:
- Reset, enable rise, then scenario_state 0→1 at cycle 10 → one record, ts=9, state=1, mask=0x01; rd_valid high next cycle.
- detonation_signal rise and scenario_state 3→4 in the same cycle at ts=500 → a single record, mask=0x03, state=4.
- rd_ready held low, 20 state changes with DEPTH=16 → fill_level=16, overflow=1, drop_count=4. Readout returns the first 16 records in order.
- At full, simultaneous pop and new event → fill_level stays 16, drop_count unchanged, new record at tail.
- reset_signal=0 for one cycle mid-shot with 5 records stored → rd_valid=0, fill_level=0, overflow=0, drop_count=0 next cycle.
- TS_W=8 with the macro defined, enable held 256 cycles with no input change → one record, ts=255, mask=0x20. With the macro undefined → no record.

Source files
------------

// File: rtl/fsm_logger_pkg.sv
// rtl/fsm_logger_pkg.sv - event bit indices, record layout and mask helper for fsm_event_logger
package fsm_logger_pkg;

  localparam int EV_STATE     = 0;
  localparam int EV_DET_RISE  = 1;
  localparam int EV_DET_FALL  = 2;
  localparam int EV_TRIG_RISE = 3;
  localparam int EV_TRIG_FALL = 4;
  localparam int EV_WRAP      = 5;

  localparam int TS_W_DEF = 32;
  localparam int TAG_W    = 16;

  typedef struct packed {
    logic [TS_W_DEF-1:0] ts;
    logic [7:0]          state;
    logic [7:0]          mask;
  } event_record_t;

  localparam int RECORD_W = $bits(event_record_t);

  function automatic logic [7:0] edge_mask(
    input logic state_chg,
    input logic det,
    input logic det_prev,
    input logic trig,
    input logic trig_prev,
    input logic wrap
  );
    logic [7:0] m;
    m               = '0;
    m[EV_STATE]     = state_chg;
    m[EV_DET_RISE]  = det & ~det_prev;
    m[EV_DET_FALL]  = ~det & det_prev;
    m[EV_TRIG_RISE] = trig & ~trig_prev;
    m[EV_TRIG_FALL] = ~trig & trig_prev;
    m[EV_WRAP]      = wrap;
    return m;
  endfunction

endpackage

// File: rtl/logger_fifo.sv
// rtl/logger_fifo.sv - synchronous first-word-fall-through FIFO with fill level
module logger_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  // A write into a full FIFO is only accepted when the head leaves in the same cycle.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == FULL_CNT);
    do_rd      = rd_en & ~empty;
    do_wr      = wr_en & (~full | do_rd);
    wr_ptr_d   = wr_ptr_q + AW'(do_wr);
    rd_ptr_d   = rd_ptr_q + AW'(do_rd);
    count_d    = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    rd_valid   = ~empty;
    rd_data    = empty ? '0 : mem_q[rd_ptr_q];
    fill_level = count_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/fsm_event_logger.sv
// rtl/fsm_event_logger.sv - timestamps FSM state/detonation/trigger edges into a FWFT FIFO
// Optional EVENT_LOGGER_WRAP_EVENT_EN adds a record when the timestamp counter is all-ones.
module fsm_event_logger
  import fsm_logger_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int TS_W   = 32,
  parameter int DROP_W = 16
) (
  input  logic                      clock,
  input  logic                      reset_signal,
  input  logic                      enable,
  input  logic [7:0]                scenario_state,
  input  logic                      detonation_signal,
  input  logic                      output_trigger,
  input  logic                      rd_ready,
  input  logic                      clear_flags,
  output logic                      rd_valid,
  output logic [TS_W+TAG_W-1:0]     rd_data,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_count
);

  localparam logic [TS_W-1:0]   TS_ONE   = 1;
  localparam logic [DROP_W-1:0] DROP_ONE = 1;

  logic                   en_prev_q, en_prev_d;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic [7:0]             state_prev_q, state_prev_d;
  logic                   det_prev_q, det_prev_d;
  logic                   trig_prev_q, trig_prev_d;
  logic                   overflow_q, overflow_d;
  logic [DROP_W-1:0]      drop_q, drop_d;

  logic                   rise, active, wrap_hit;
  logic [7:0]             mask;
  logic                   wr_req, pop, drop;
  logic [TS_W+TAG_W-1:0]  wr_data;
  logic                   fifo_full, fifo_empty;

  always_comb begin
    rise   = enable & ~en_prev_q;
    active = enable & en_prev_q;
`ifdef EVENT_LOGGER_WRAP_EVENT_EN
    wrap_hit = &ts_q;
`else
    wrap_hit = 1'b0;
`endif
    mask = active ? edge_mask(scenario_state != state_prev_q, detonation_signal, det_prev_q,
                              output_trigger, trig_prev_q, wrap_hit)
                  : 8'h00;
    wr_req  = |mask;
    wr_data = {ts_q, scenario_state, mask};
    pop     = rd_ready & ~fifo_empty;
    drop    = wr_req & fifo_full & ~pop;

    en_prev_d = enable;
    ts_d      = ts_q;
    if (rise) begin
      ts_d = '0;
    end else if (enable) begin
      ts_d = ts_q + TS_ONE;
    end

    state_prev_d = state_prev_q;
    det_prev_d   = det_prev_q;
    trig_prev_d  = trig_prev_q;
    if (enable) begin
      state_prev_d = scenario_state;
      det_prev_d   = detonation_signal;
      trig_prev_d  = output_trigger;
    end

    // Clearing first and then applying the drop lets a same-cycle drop win over clear_flags.
    overflow_d = clear_flags ? 1'b0 : overflow_q;
    drop_d     = clear_flags ? '0 : drop_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (~&drop_d) begin
        drop_d = drop_d + DROP_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_signal) begin
      en_prev_q    <= 1'b0;
      ts_q         <= '0;
      state_prev_q <= '0;
      det_prev_q   <= 1'b0;
      trig_prev_q  <= 1'b0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      en_prev_q    <= en_prev_d;
      ts_q         <= ts_d;
      state_prev_q <= state_prev_d;
      det_prev_q   <= det_prev_d;
      trig_prev_q  <= trig_prev_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
    end
  end

  logger_fifo #(
    .WIDTH (TS_W + TAG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clock),
    .resetn     (reset_signal),
    .wr_en      (wr_req),
    .wr_data    (wr_data),
    .rd_en      (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .fill_level (fill_level),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_fsm_event_logger.sv
// tb/tb_fsm_event_logger.sv - scoreboard bench for fsm_event_logger (32-bit and 8-bit timestamp builds)
module tb_fsm_event_logger;

  logic        clock;
  logic        reset_signal, enable, det, trig, rd_ready, clear_flags;
  logic [7:0]  scenario_state;
  logic        rd_valid, overflow;
  logic [47:0] rd_data;
  logic [4:0]  fill_level;
  logic [15:0] drop_count;

  logic        w_reset, w_enable, w_rd_ready;
  logic        w_rd_valid, w_overflow;
  logic [23:0] w_rd_data;
  logic [2:0]  w_fill;
  logic [15:0] w_drop;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int c0      = 0;

  logic [47:0] exp_q[$];
  logic [23:0] wexp_q[$];
  logic [47:0] mexp;
  logic [23:0] wmexp;

  fsm_event_logger #(.DEPTH(16), .TS_W(32), .DROP_W(16)) u_dut (
    .clock             (clock),
    .reset_signal      (reset_signal),
    .enable            (enable),
    .scenario_state    (scenario_state),
    .detonation_signal (det),
    .output_trigger    (trig),
    .rd_ready          (rd_ready),
    .clear_flags       (clear_flags),
    .rd_valid          (rd_valid),
    .rd_data           (rd_data),
    .fill_level        (fill_level),
    .overflow          (overflow),
    .drop_count        (drop_count)
  );

  fsm_event_logger #(.DEPTH(4), .TS_W(8), .DROP_W(16)) u_wrap (
    .clock             (clock),
    .reset_signal      (w_reset),
    .enable            (w_enable),
    .scenario_state    (8'h00),
    .detonation_signal (1'b0),
    .output_trigger    (1'b0),
    .rd_ready          (w_rd_ready),
    .clear_flags       (1'b0),
    .rd_valid          (w_rd_valid),
    .rd_data           (w_rd_data),
    .fill_level        (w_fill),
    .overflow          (w_overflow),
    .drop_count        (w_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic push_rec(input logic [7:0] st, input logic [7:0] m);
    exp_q.push_back({32'(cyc - c0), st, m});
  endtask

  task automatic drain(input string name, input int max_cyc);
    rd_ready = 1'b1;
    for (int i = 0; i < max_cyc && rd_valid; i++) tick();
    rd_ready = 1'b0;
    check(name, 64'(rd_valid), 64'd0);
  endtask

  always @(negedge clock) begin
    if (reset_signal && rd_valid && rd_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rec_unexpected got=%h required=none", rd_data);
      end else begin
        mexp = exp_q.pop_front();
        if (rd_data !== mexp) begin
          n_fail++;
          $display("FAIL rec_main got=%h required=%h", rd_data, mexp);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (w_reset && w_rd_valid && w_rd_ready) begin
      n_tests++;
      if (wexp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rec_wrap_unexpected got=%h required=none", w_rd_data);
      end else begin
        wmexp = wexp_q.pop_front();
        if (w_rd_data !== wmexp) begin
          n_fail++;
          $display("FAIL rec_wrap got=%h required=%h", w_rd_data, wmexp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_signal = 0; enable = 0; det = 0; trig = 0; rd_ready = 0; clear_flags = 0;
    scenario_state = 0;
    w_reset = 0; w_enable = 0; w_rd_ready = 0;
    repeat (3) tick();

    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_fill", 64'(fill_level), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);

    // Wrap build: 8-bit timestamp, no input activity for 256 counting cycles
    w_reset = 1; w_enable = 1;
    tick();
    repeat (255) tick();
    check("wrap_before", 64'(w_fill), 64'd0);
    tick();
`ifdef EVENT_LOGGER_WRAP_EVENT_EN
    check("wrap_fill", 64'(w_fill), 64'd1);
    wexp_q.push_back({8'd255, 8'd0, 8'h20});
    w_rd_ready = 1;
    tick();
    w_rd_ready = 0;
`else
    check("wrap_fill", 64'(w_fill), 64'd0);
    check("wrap_valid", 64'(w_rd_valid), 64'd0);
`endif
    w_enable = 0;

    // First shot: state change sampled 10 edges after the rising enable edge
    reset_signal = 1; enable = 1;
    tick();
    c0 = cyc;
    repeat (9) tick();
    scenario_state = 8'd1;
    exp_q.push_back({32'd9, 8'd1, 8'h01});
    tick();
    check("first_valid", 64'(rd_valid), 64'd1);
    check("first_fill", 64'(fill_level), 64'd1);
    rd_ready = 1;
    tick();
    rd_ready = 0;

    scenario_state = 8'd3;
    push_rec(8'd3, 8'h01);
    tick();
    while (cyc - c0 < 500) tick();
    det = 1; scenario_state = 8'd4;
    exp_q.push_back({32'd500, 8'd4, 8'h03});
    tick();
    trig = 1;
    push_rec(8'd4, 8'h08);
    tick();
    trig = 0; det = 0;
    push_rec(8'd4, 8'h14);
    tick();
    tick();
    check("hold_fill", 64'(fill_level), 64'd4);
    drain("drain_a", 10);

    // Overflow: 20 state changes into a 16-deep FIFO, oldest kept
    for (int i = 0; i < 20; i++) begin
      scenario_state = 8'(10 + i);
      if (i < 16) push_rec(scenario_state, 8'h01);
      tick();
    end
    check("ovf_fill", 64'(fill_level), 64'd16);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_drop", 64'(drop_count), 64'd4);

    rd_ready = 1; scenario_state = 8'd40;
    push_rec(8'd40, 8'h01);
    tick();
    rd_ready = 0;
    check("full_swap_fill", 64'(fill_level), 64'd16);
    check("full_swap_drop", 64'(drop_count), 64'd4);
    drain("drain_b", 40);

    clear_flags = 1;
    tick();
    clear_flags = 0;
    check("clr_overflow", 64'(overflow), 64'd0);
    check("clr_drop", 64'(drop_count), 64'd0);

    for (int i = 0; i < 16; i++) begin
      scenario_state = 8'(50 + i);
      push_rec(scenario_state, 8'h01);
      tick();
    end
    clear_flags = 1; scenario_state = 8'd66;
    tick();
    clear_flags = 0;
    check("clr_drop_ovf", 64'(overflow), 64'd1);
    check("clr_drop_cnt", 64'(drop_count), 64'd1);
    check("clr_drop_fill", 64'(fill_level), 64'd16);

    rd_ready = 1;
    repeat (11) tick();
    rd_ready = 0;
    check("pre_rst_fill", 64'(fill_level), 64'd5);

    // Mid-shot reset discards the five stored records
    reset_signal = 0;
    tick();
    exp_q.delete();
    check("mid_rst_valid", 64'(rd_valid), 64'd0);
    check("mid_rst_fill", 64'(fill_level), 64'd0);
    check("mid_rst_ovf", 64'(overflow), 64'd0);
    check("mid_rst_drop", 64'(drop_count), 64'd0);
    reset_signal = 1;
    tick();
    c0 = cyc;

    // Write and rd_ready together into an empty FIFO: record survives one cycle
    scenario_state = 8'd70; rd_ready = 1;
    push_rec(8'd70, 8'h01);
    tick();
    check("empty_wr_fill", 64'(fill_level), 64'd1);
    check("empty_wr_valid", 64'(rd_valid), 64'd1);
    tick();
    rd_ready = 0;
    check("final_fill", 64'(fill_level), 64'd0);
    check("sb_main_empty", 64'(exp_q.size()), 64'd0);
    check("sb_wrap_empty", 64'(wexp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
